adder_pipe_reg: RTL and testbench
=================================

Name: adder_pipe_reg

Overview:
- Parametrised pipelined adder/subtractor; successor to the single-register adder.
- Splits the WIDTH-bit carry chain into STAGES equal chunks, one register stage per chunk.
- Adds an add/sub mode and a valid/ready handshake with full-pipeline backpressure.
- Sits between operand producers and the result consumer in the datapath.

Parameters:
- WIDTH, 32, operand and sum width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of carry-chain chunks (1..WIDTH). STAGES=1 gives a plain registered adder.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry-in; used only when sub=0
- sub  in  1  0: a+b+ci; 1: a-b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result this cycle
- s  out  WIDTH  sum/difference
- co  out  1  carry-out; for sub=1 this is the no-borrow flag (1 when a>=b unsigned)

Behaviour:
- Chunk width C = WIDTH/STAGES. Elaboration fails (generate-time error) if WIDTH % STAGES != 0.
- Operand conditioning at input:
  - b_eff = sub ? ~b : b
  - c0 = sub ? 1 : ci
- Stage k (0..STAGES-1) adds chunk k of a and b_eff plus the carry from stage k-1 (c0 for k=0). It registers:
  - the chunk sum,
  - the carry,
  - the not-yet-consumed upper operand chunks,
  - the already-computed lower sum chunks,
  - its valid bit.
- Final stage registers drive s, co and out_valid directly. No combinational path from a/b to s.
- Advance rule: adv = !out_valid | out_ready; in_ready = adv.
  - Every stage register, including the valid bits, loads only when adv=1.
  - When adv=0 the whole pipeline holds; s and co stay stable while out_valid=1 and out_ready=0.
- Accept: transfer occurs on an edge where in_valid & in_ready.
  - Result appears with out_valid=1 after exactly STAGES rising edges, counting the accept edge, provided no stall occurs.
  - Each stall cycle adds one cycle.
- Bubbles: an edge with in_valid=0 and adv=1 inserts valid=0 into stage 0. Bubbles are not collapsed.
- Throughput: 1 result per cycle while out_ready=1.
- Wrap-around: arithmetic is modulo 2^WIDTH; co is the carry out of bit WIDTH-1.
- Ordering: results leave in acceptance order; sub and ci travel with their own operands.
- Reset (rst=1 at an edge):
  - all valid bits, s, co and all pipeline registers go to 0;
  - out_valid=0;
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation drops every in-flight result silently. Operands presented in the reset cycle are not accepted.
- Simultaneous events:
  - out_ready=1 and in_valid=1 with a full pipeline: the result leaves and new operands enter on the same edge.
  - rst has priority over everything.
- When out_valid=0, s and co hold whatever the final stage last loaded; the bench must not check them.

Optional Feature:
- Macro: ADDER_PIPE_OVF_EN.
- Defined: adds output port ovf (out, 1), the two's-complement signed overflow.
  - Computed as carry into MSB XOR carry out of MSB, on b_eff.
  - Pipelined alongside s and obeys the same valid, stall and reset rules (reset value 0).
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then single add: WIDTH=32, STAGES=4, a=0x0000_0001, b=0x0000_0002, ci=1, sub=0, out_ready=1 -> out_valid=1 exactly 4 edges after accept; s=0x0000_0004, co=0.
- Full carry ripple across all chunks: a=0xFFFF_FFFF, b=0x0000_0000, ci=1 -> s=0x0000_0000, co=1. With ADDER_PIPE_OVF_EN: ovf=0.
- Subtract with borrow: sub=1, a=5, b=7, ci=1 (ignored) -> s=0xFFFF_FFFE, co=0. Then a=7, b=5 -> s=2, co=1. With ADDER_PIPE_OVF_EN: a=0x8000_0000, b=1 -> ovf=1.
- Back-to-back stream with backpressure:
  - 8 consecutive operand sets (a=i, b=i*3, ci=0); hold out_ready=0 for 3 cycles once out_valid rises.
  - Required: in_ready=0 during the stall, s/co stable, no loss or duplication.
  - Results 4*i emerge in order, one per cycle after release.
- Reset mid-flight: accept 3 operand sets, assert rst for 1 cycle before any emerges -> out_valid stays 0 for the next 4 cycles; in_ready=1 the cycle after reset; a new operand set completes normally.
- STAGES=1 and STAGES=32 builds (WIDTH=32): random add/sub against a reference model over 1000 transactions -> latency 1 and 32 respectively; all results match.

Source files
------------

// File: rtl/adder_pipe_reg.sv
// Pipelined adder/subtractor: the WIDTH-bit carry chain is cut into STAGES equal chunks,
// one register stage per chunk. Define ADDER_PIPE_OVF_EN to add the signed-overflow output ovf.
module adder_pipe_reg #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef ADDER_PIPE_OVF_EN
    output logic             ovf,
`endif
    output logic             co
);
    localparam int C = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("adder_pipe_reg: WIDTH must be a non-zero multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // The whole pipeline moves as one unit; a full output register blocks everything.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | ci;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int OW = WIDTH - k * C;   // operand bits not yet consumed
        localparam int SW = (k + 1) * C;     // sum bits already produced

        logic [OW-1:0] a_in, b_in;
        logic          c_in, v_in;
        logic [C:0]    chunk;
        logic [SW-1:0] s_d, s_q;
        logic          c_q, v_q;

        if (k == 0) begin : g_src
            assign a_in = a;
            assign b_in = b_eff;
            assign c_in = c0;
            assign v_in = in_valid;
            assign s_d  = chunk[C-1:0];
        end else begin : g_src
            assign a_in = g_st[k-1].g_fwd.a_q;
            assign b_in = g_st[k-1].g_fwd.b_q;
            assign c_in = g_st[k-1].c_q;
            assign v_in = g_st[k-1].v_q;
            assign s_d  = {chunk[C-1:0], g_st[k-1].s_q};
        end

        assign chunk = {1'b0, a_in[C-1:0]} + {1'b0, b_in[C-1:0]} + {{C{1'b0}}, c_in};

        always_ff @(posedge clk) begin
            if (rst) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_d;
                c_q <= chunk[C];
                v_q <= v_in;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [OW-C-1:0] a_q, b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[OW-1:C];
                    b_q <= b_in[OW-1:C];
                end
            end
        end

`ifdef ADDER_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_d, ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit (s = a ^ b ^ cin).
            assign ovf_d = (a_in[C-1] ^ b_in[C-1] ^ chunk[C-1]) ^ chunk[C];

            always_ff @(posedge clk) begin
                if (rst)      ovf_q <= 1'b0;
                else if (adv) ovf_q <= ovf_d;
            end
        end
`endif
    end

    assign s         = g_st[STAGES-1].s_q;
    assign co        = g_st[STAGES-1].c_q;
    assign out_valid = g_st[STAGES-1].v_q;
`ifdef ADDER_PIPE_OVF_EN
    assign ovf       = g_st[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipe_reg.sv
// Bench for adder_pipe_reg: directed cases on a 4-stage build, plus a random
// scoreboard run shared by 1-, 4- and 32-stage builds.
module tb_adder_pipe_reg;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           due;
    } exp_t;

    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, ci = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready4, in_ready1, in_ready32;
    logic         ovld4, ovld1, ovld32, co4, co1, co32;
    logic [W-1:0] s4, s1, s32;
`ifdef ADDER_PIPE_OVF_EN
    logic         ovf4, ovf1, ovf32;
`endif

    int errors = 0, checks = 0, cyc = 0;
    exp_t sbq[3][$];
    logic [2:0]   vo, cout;
    logic [W-1:0] so[3];
    int           lat_of[3] = '{4, 1, 32};

    assign vo    = {ovld32, ovld1, ovld4};
    assign cout  = {co32, co1, co4};
    assign so[0] = s4;
    assign so[1] = s1;
    assign so[2] = s32;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_pipe_reg #(.WIDTH(W), .STAGES(4)) d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b),
        .ci(ci), .sub(sub), .out_valid(ovld4), .out_ready(out_ready), .s(s4),
`ifdef ADDER_PIPE_OVF_EN
        .ovf(ovf4),
`endif
        .co(co4));

    adder_pipe_reg #(.WIDTH(W), .STAGES(1)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
        .ci(ci), .sub(sub), .out_valid(ovld1), .out_ready(1'b1), .s(s1),
`ifdef ADDER_PIPE_OVF_EN
        .ovf(ovf1),
`endif
        .co(co1));

    adder_pipe_reg #(.WIDTH(W), .STAGES(32)) d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .a(a), .b(b),
        .ci(ci), .sub(sub), .out_valid(ovld32), .out_ready(1'b1), .s(s32),
`ifdef ADDER_PIPE_OVF_EN
        .ovf(ovf32),
`endif
        .co(co32));

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic m, input int due);
        logic [W-1:0] be;
        logic [W:0]   r;
        exp_t         e;
        be    = m ? ~y : y;
        r     = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, (m | c)};
        e.s   = r[W-1:0];
        e.co  = r[W];
        e.ov  = (x[W-1] == be[W-1]) && (r[W-1] != x[W-1]);
        e.due = due;
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (ovld4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", ovld4); end
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready4); end
        checks++; if (s4 !== '0) begin errors++; $display("FAIL reset_s got=%h want=0", s4); end
        checks++; if (co4 !== 1'b0) begin errors++; $display("FAIL reset_co got=%b want=0", co4); end
        checks++; if (ovld1 !== 1'b0 || ovld32 !== 1'b0) begin errors++; $display("FAIL reset_valid_s1_s32 got=%b%b want=00", ovld1, ovld32); end
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [W-1:0] ta[6]   = '{32'h1, 32'hFFFF_FFFF, 32'h5, 32'h7, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [W-1:0] tb_[6]  = '{32'h2, 32'h0, 32'h7, 32'h5, 32'h1, 32'h1};
        logic         tci[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic         tsub[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] ts[6]   = '{32'h4, 32'h0, 32'hFFFF_FFFE, 32'h2, 32'h7FFF_FFFF, 32'h8000_0000};
        logic         tco[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic         tov[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int t0, lat;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = ta[i]; b = tb_[i]; ci = tci[i]; sub = tsub[i]; in_valid = 1'b1;
            @(negedge clk);
            t0 = cyc;
            checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL arith%0d_in_ready got=%b want=1", i, in_ready4); end
            @(posedge clk); #1 in_valid = 1'b0;
            lat = -1;
            for (int n = 0; n < 20 && lat < 0; n++) begin
                @(negedge clk);
                if (ovld4) lat = cyc - t0;
            end
            checks++; if (lat != 4) begin errors++; $display("FAIL arith%0d_latency got=%0d want=4", i, lat); end
            checks++; if (s4 !== ts[i]) begin errors++; $display("FAIL arith%0d_s got=%h want=%h", i, s4, ts[i]); end
            checks++; if (co4 !== tco[i]) begin errors++; $display("FAIL arith%0d_co got=%b want=%b", i, co4, tco[i]); end
`ifdef ADDER_PIPE_OVF_EN
            checks++; if (ovf4 !== tov[i]) begin errors++; $display("FAIL arith%0d_ovf got=%b want=%b", i, ovf4, tov[i]); end
`else
            if (tov[i] === 1'bx) $display("arith%0d: unexpected X in ovf table", i);
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] bq[$];
        logic [W-1:0] hold_s, e;
        logic         hold_co, started;
        int sent, got, stall;
        sent = 0; got = 0; stall = 0; started = 1'b0; hold_s = '0; hold_co = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 40 && got < 8; n++) begin
            in_valid = (sent < 8); a = W'(sent); b = W'(3 * sent); ci = 1'b0; sub = 1'b0;
            @(negedge clk);
            if (ovld4 && !started) begin
                started = 1'b1; stall = 3; hold_s = s4; hold_co = co4;
            end else if (stall > 0) begin
                checks++; if (ovld4 !== 1'b1) begin errors++; $display("FAIL b2b_stall_valid got=%b want=1", ovld4); end
                checks++; if (s4 !== hold_s) begin errors++; $display("FAIL b2b_stall_s got=%h want=%h", s4, hold_s); end
                checks++; if (co4 !== hold_co) begin errors++; $display("FAIL b2b_stall_co got=%b want=%b", co4, hold_co); end
            end
            out_ready = (stall == 0);
            #1;
            if (started && stall == 0) begin
                checks++; if (ovld4 !== 1'b1) begin errors++; $display("FAIL b2b_stream_gap got=%b want=1 at result %0d", ovld4, got); end
            end
            if (stall > 0) begin
                checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready got=%b want=0", in_ready4); end
                stall--;
            end
            if (in_valid && in_ready4) begin bq.push_back(W'(4 * sent)); sent++; end
            if (ovld4 && out_ready) begin
                if (bq.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_extra got=%h want=none", s4);
                end else begin
                    e = bq.pop_front();
                    checks++; if (s4 !== e || co4 !== 1'b0) begin errors++; $display("FAIL b2b_result%0d got=%h/%b want=%h/0", got, s4, co4, e); end
                end
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 8 || bq.size() != 0) begin errors++; $display("FAIL b2b_count got=%0d left=%0d want=8/0", got, bq.size()); end
        repeat (6) @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int t0, lat;
        out_ready = 1'b1; ci = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = W'(100 + i); b = W'(i); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1; a = 32'd55; b = 32'd55;
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready4); end
        for (int n = 0; n < 4; n++) begin
            if (n > 0) @(negedge clk);
            checks++; if (ovld4 !== 1'b0) begin errors++; $display("FAIL rstmid_valid%0d got=%b want=0", n, ovld4); end
        end
        @(posedge clk); #1;
        a = 32'd10; b = 32'd20; in_valid = 1'b1;
        @(negedge clk);
        t0 = cyc;
        @(posedge clk); #1 in_valid = 1'b0;
        lat = -1;
        for (int n = 0; n < 20 && lat < 0; n++) begin
            @(negedge clk);
            if (ovld4) lat = cyc - t0;
        end
        checks++; if (lat != 4) begin errors++; $display("FAIL rstmid_latency got=%0d want=4", lat); end
        checks++; if (s4 !== 32'd30 || co4 !== 1'b0) begin errors++; $display("FAIL rstmid_result got=%h/%b want=0000001e/0", s4, co4); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        exp_t e;
        logic exp_v;
        int   acc;
        acc = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int d = 0; d < 3; d++) sbq[d].delete();
        for (int n = 0; n < 3000 && (acc < 1000 || sbq[0].size() + sbq[1].size() + sbq[2].size() > 0); n++) begin
            in_valid = (acc < 1000) && ($urandom_range(3) != 0);
            a = ($urandom_range(7) == 0) ? '1 : W'($urandom);
            b = ($urandom_range(7) == 0) ? '0 : W'($urandom);
            ci = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                exp_v = (sbq[d].size() > 0) && (sbq[d][0].due == cyc);
                checks++;
                if (vo[d] !== exp_v) begin errors++; $display("FAIL rand_valid stages=%0d cyc=%0d got=%b want=%b", lat_of[d], cyc, vo[d], exp_v); end
                if (exp_v) begin
                    e = sbq[d].pop_front();
                    if (vo[d]) begin
                        checks++;
                        if (so[d] !== e.s || cout[d] !== e.co) begin
                            errors++; $display("FAIL rand_result stages=%0d got=%h/%b want=%h/%b", lat_of[d], so[d], cout[d], e.s, e.co);
                        end
`ifdef ADDER_PIPE_OVF_EN
                        if (d == 0) begin
                            checks++; if (ovf4 !== e.ov) begin errors++; $display("FAIL rand_ovf got=%b want=%b", ovf4, e.ov); end
                        end
`endif
                    end
                end
            end
            if (in_valid) begin
                checks++; if (in_ready4 !== 1'b1 || in_ready1 !== 1'b1 || in_ready32 !== 1'b1) begin
                    errors++; $display("FAIL rand_in_ready got=%b%b%b want=111", in_ready4, in_ready1, in_ready32);
                end
                for (int d = 0; d < 3; d++) sbq[d].push_back(model(a, b, ci, sub, cyc + lat_of[d]));
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (acc != 1000 || sbq[0].size() + sbq[1].size() + sbq[2].size() != 0) begin
            errors++; $display("FAIL rand_drain accepted=%0d left=%0d want=1000/0", acc, sbq[0].size() + sbq[1].size() + sbq[2].size());
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
